// File: rtl/label_pkg.sv
// Shared widths, FSM states, type codes and request record for the label allocator.
package label_pkg;

  localparam int LBID_W = 12;
  localparam int ADDR_W = 16;
  localparam int TYP_W  = 8;
  localparam int NDEF_W = 13;

  localparam logic [NDEF_W-1:0] NDEF_MAX = 13'd4096;

  localparam logic [TYP_W-1:0] TYP_UNDEF = 8'h00;
  localparam logic [TYP_W-1:0] TYP_DATA  = 8'h06;
  localparam logic [TYP_W-1:0] TYP_CODE  = 8'h86;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // src: 0 = decoder, 1 = host
  typedef struct packed {
    logic              src;
    logic [LBID_W-1:0] lbid;
    logic [TYP_W-1:0]  typ;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] count;
  } req_t;

  // Last word of a block, one bit wider so overflow past 16'hFFFF is visible.
  function automatic logic [ADDR_W:0] alloc_end(input logic [ADDR_W-1:0] base,
                                                input logic [ADDR_W-1:0] count);
    return {1'b0, base} + {1'b0, count} - {{ADDR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/label_alloc_ctrl_if.sv
// Request, label-table write and completion signals of the label allocator.
interface label_alloc_ctrl_if;
  import label_pkg::*;

  logic              d_valid;
  logic              d_ready;
  logic [LBID_W-1:0] d_lbid;
  logic [TYP_W-1:0]  d_typ;
  logic [ADDR_W-1:0] d_count;

  logic              h_valid;
  logic              h_ready;
  logic [LBID_W-1:0] h_lbid;
  logic [TYP_W-1:0]  h_typ;
  logic [ADDR_W-1:0] h_base;
  logic [ADDR_W-1:0] h_count;

  logic              clr;

  logic              we;
  logic [LBID_W-1:0] lbidw;
  logic [TYP_W-1:0]  typw;
  logic [ADDR_W-1:0] basew;
  logic [ADDR_W-1:0] countw;

  logic              done;
  logic              done_src;
  logic [ADDR_W-1:0] done_base;
  logic              err;
  logic [ADDR_W-1:0] free_ptr;
  logic [NDEF_W-1:0] n_defined;

  modport master (
    output d_valid, d_lbid, d_typ, d_count,
    output h_valid, h_lbid, h_typ, h_base, h_count,
    output clr,
    input  d_ready, h_ready,
    input  we, lbidw, typw, basew, countw,
    input  done, done_src, done_base, err, free_ptr, n_defined
  );

  modport slave (
    input  d_valid, d_lbid, d_typ, d_count,
    input  h_valid, h_lbid, h_typ, h_base, h_count,
    input  clr,
    output d_ready, h_ready,
    output we, lbidw, typw, basew, countw,
    output done, done_src, done_base, err, free_ptr, n_defined
  );

endinterface

// File: rtl/label_rr_arb.sv
// 2-way round-robin arbiter (bit 0 decoder, bit 1 host): combinational grant, zero latency.
// Requesters hold req until served; the priority pointer moves only when en accepts a grant.
module label_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic host_first;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = host_first ? 2'b10 : 2'b01;
  end

  // Whoever was just granted loses the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_first <= 1'b0;
    else if (en && (gnt != 2'b00)) host_first <= gnt[0];
  end

endmodule

// File: rtl/label_alloc_ctrl.sv
// Label allocator: arbitrates decoder/host defines, allocates word ranges, writes the label table.
// Registered outputs: ready +1, we +2, done +3 (+2 on error) from ready; one request per 4 cycles, valids held until ready.
module label_alloc_ctrl
  import label_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ALLOC_LIMIT = 16'hFFFF
) (
  input logic               clk,
  input logic               rst_n,
  label_alloc_ctrl_if.slave bus
);

  state_t            state, state_nxt;
  req_t              cap, cap_nxt;
  logic              bad, bad_nxt;
  logic [ADDR_W-1:0] end_q, end_nxt;

  logic [1:0]        gnt;
  logic              arb_en;
  logic [ADDR_W-1:0] alloc_base;
  logic [ADDR_W:0]   end17;

  logic              d_ready_nxt, h_ready_nxt;
  logic              we_nxt;
  logic [LBID_W-1:0] lbidw_nxt;
  logic [TYP_W-1:0]  typw_nxt;
  logic [ADDR_W-1:0] basew_nxt, countw_nxt;
  logic              done_nxt, done_src_nxt, err_nxt;
  logic [ADDR_W-1:0] done_base_nxt;
  logic [ADDR_W-1:0] free_nxt;
  logic [NDEF_W-1:0] ndef_nxt;

  // clr in IDLE wins over any request, so the pointer must not move either.
  assign arb_en = (state == IDLE) && !bus.clr;

  label_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.h_valid, bus.d_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign alloc_base = cap.src ? cap.base : bus.free_ptr;
  assign end17      = alloc_end(alloc_base, cap.count);

  always_comb begin
    state_nxt     = state;
    cap_nxt       = cap;
    bad_nxt       = bad;
    end_nxt       = end_q;
    d_ready_nxt   = 1'b0;
    h_ready_nxt   = 1'b0;
    we_nxt        = 1'b0;
    lbidw_nxt     = '0;
    typw_nxt      = '0;
    basew_nxt     = '0;
    countw_nxt    = '0;
    done_nxt      = 1'b0;
    done_src_nxt  = 1'b0;
    done_base_nxt = '0;
    err_nxt       = 1'b0;
    free_nxt      = bus.free_ptr;
    ndef_nxt      = bus.n_defined;

    case (state)
      IDLE: begin
        if (bus.clr) begin
          free_nxt = '0;
          ndef_nxt = '0;
        end else if (gnt[0]) begin
          d_ready_nxt = 1'b1;
          cap_nxt     = '{src: 1'b0, lbid: bus.d_lbid, typ: bus.d_typ, base: '0, count: bus.d_count};
          state_nxt   = ALLOC;
        end else if (gnt[1]) begin
          h_ready_nxt = 1'b1;
          cap_nxt     = '{src: 1'b1, lbid: bus.h_lbid, typ: bus.h_typ, base: bus.h_base, count: bus.h_count};
          state_nxt   = ALLOC;
        end
      end

      ALLOC: begin
        // The 17-bit compare also catches ranges running past 16'hFFFF.
        cap_nxt.base = alloc_base;
        end_nxt      = end17[ADDR_W-1:0];
        bad_nxt      = (cap.count == '0) || (end17 > {1'b0, ALLOC_LIMIT});
        state_nxt    = bad_nxt ? RESP : WRITE;
      end

      WRITE: begin
        we_nxt     = 1'b1;
        lbidw_nxt  = cap.lbid;
        typw_nxt   = cap.typ;
        basew_nxt  = cap.base;
        countw_nxt = cap.count;
        if (!cap.src) free_nxt = end_q + ADDR_W'(1);
        if (bus.n_defined != NDEF_MAX) ndef_nxt = bus.n_defined + NDEF_W'(1);
        state_nxt  = RESP;
      end

      RESP: begin
        done_nxt      = 1'b1;
        done_src_nxt  = cap.src;
        done_base_nxt = cap.base;
        err_nxt       = bad;
        state_nxt     = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cap           <= '0;
      bad           <= 1'b0;
      end_q         <= '0;
      bus.d_ready   <= 1'b0;
      bus.h_ready   <= 1'b0;
      bus.we        <= 1'b0;
      bus.lbidw     <= '0;
      bus.typw      <= '0;
      bus.basew     <= '0;
      bus.countw    <= '0;
      bus.done      <= 1'b0;
      bus.done_src  <= 1'b0;
      bus.done_base <= '0;
      bus.err       <= 1'b0;
      bus.free_ptr  <= '0;
      bus.n_defined <= '0;
    end else begin
      state         <= state_nxt;
      cap           <= cap_nxt;
      bad           <= bad_nxt;
      end_q         <= end_nxt;
      bus.d_ready   <= d_ready_nxt;
      bus.h_ready   <= h_ready_nxt;
      bus.we        <= we_nxt;
      bus.lbidw     <= lbidw_nxt;
      bus.typw      <= typw_nxt;
      bus.basew     <= basew_nxt;
      bus.countw    <= countw_nxt;
      bus.done      <= done_nxt;
      bus.done_src  <= done_src_nxt;
      bus.done_base <= done_base_nxt;
      bus.err       <= err_nxt;
      bus.free_ptr  <= free_nxt;
      bus.n_defined <= ndef_nxt;
    end
  end

endmodule
